vga_timing_gen: RTL

Parametrised successor to the fixed 640x480 VGA driver. It generates pixel-clock-enable, sync, blanking and fetch coordinates from one system clock, with timing, sync polarity, colour depth and fetch latency all configurable. Fetch coordinates lead the display outputs by FETCH_LAT pixel ticks, so pipelined pixel sources (sync BRAM, sprite mixers) stay aligned. It also adds line/frame strobes, a frame counter and a synchronous enable.

---
 rtl/vga_timing_gen_if.sv | 41 ++++
 rtl/vga_timing_gen.sv | 133 +++++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// Pixel-source side of the VGA timing generator: run control, colour in,
// fetch coordinates/strobes and display-stage sync/blank/RGB out.
interface vga_timing_gen_if #(
  parameter int R_BITS  = 3,
  parameter int G_BITS  = 3,
  parameter int B_BITS  = 2,
  parameter int X_W     = 10,
  parameter int Y_W     = 10,
  parameter int FRAME_W = 16
);
  localparam int C_W = R_BITS + G_BITS + B_BITS;

  logic               ENABLE;
  logic [C_W-1:0]     COLOR;
  logic               PIX_EN;
  logic [X_W-1:0]     CURX;
  logic [Y_W-1:0]     CURY;
  logic               DATA_REQ;
  logic               LINE_START;
  logic               FRAME_START;
  logic [FRAME_W-1:0] FRAME_CNT;
  logic               hs_vga;
  logic               vs_vga;
  logic               HBLANK;
  logic               VBLANK;
  logic [R_BITS-1:0]  RED;
  logic [G_BITS-1:0]  GREEN;
  logic [B_BITS-1:0]  BLUE;

  modport master (
    input  ENABLE, COLOR,
    output PIX_EN, CURX, CURY, DATA_REQ, LINE_START, FRAME_START, FRAME_CNT,
           hs_vga, vs_vga, HBLANK, VBLANK, RED, GREEN, BLUE
  );

  modport slave (
    output ENABLE, COLOR,
    input  PIX_EN, CURX, CURY, DATA_REQ, LINE_START, FRAME_START, FRAME_CNT,
           hs_vga, vs_vga, HBLANK, VBLANK, RED, GREEN, BLUE
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: fetch coordinates lead the registered
// sync/blank/RGB display stage by FETCH_LAT pixel ticks.
module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int R_BITS    = 3,
  parameter int G_BITS    = 3,
  parameter int B_BITS    = 2,
  parameter int FETCH_LAT = 1,
  parameter int X_W       = 10,
  parameter int Y_W       = 10,
  parameter int FRAME_W   = 16
) (
  input  logic            clk_50MHz,
  input  logic            RESET_N,
  vga_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;
  localparam int C_W     = R_BITS + G_BITS + B_BITS;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  // All-zero means "sync inactive, blanked", so a cleared pipeline drains as blank.
  typedef struct packed {
    logic hs;
    logic vs;
    logic hvis;
    logic vvis;
  } dflag_t;

  logic             run;
  logic [DIV_W-1:0] div;
  logic             tick;
  logic [X_W-1:0]   h;
  logic [Y_W-1:0]   v;
  int               hi, vi;
  logic             h_act, v_act, at_origin;
  dflag_t           nxt_fl, out_fl;
  dflag_t           fl_pipe [FETCH_LAT];

  // run gates the tick so CLK_DIV=1 still shows PIX_EN=0 while held off.
  assign tick       = run && (div == DIV_MAX);
  assign bus.PIX_EN = tick;

  assign hi        = int'(h);
  assign vi        = int'(v);
  assign h_act     = hi < H_ACTIVE;
  assign v_act     = vi < V_ACTIVE;
  assign at_origin = (hi == 0) && (vi == 0);
  assign out_fl    = fl_pipe[FETCH_LAT-1];

  always_comb begin
    nxt_fl      = '0;
    nxt_fl.hs   = (hi >= HS_BEG) && (hi < HS_END);
    nxt_fl.vs   = (vi >= VS_BEG) && (vi < VS_END);
    nxt_fl.hvis = h_act;
    nxt_fl.vvis = v_act;
  end

  always_ff @(posedge clk_50MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      run <= 1'b0; div <= '0; h <= '0; v <= '0;
      bus.CURX <= '0; bus.CURY <= '0;
      bus.DATA_REQ <= 1'b0; bus.LINE_START <= 1'b0; bus.FRAME_START <= 1'b0;
      for (int i = 0; i < FETCH_LAT; i++) fl_pipe[i] <= '0;
      bus.hs_vga <= ~HS_ON; bus.vs_vga <= ~VS_ON;
      bus.HBLANK <= 1'b1; bus.VBLANK <= 1'b1;
      bus.RED <= '0; bus.GREEN <= '0; bus.BLUE <= '0;
    end else if (!bus.ENABLE) begin
      run <= 1'b0; div <= '0; h <= '0; v <= '0;
      bus.CURX <= '0; bus.CURY <= '0;
      bus.DATA_REQ <= 1'b0; bus.LINE_START <= 1'b0; bus.FRAME_START <= 1'b0;
      for (int i = 0; i < FETCH_LAT; i++) fl_pipe[i] <= '0;
      bus.hs_vga <= ~HS_ON; bus.vs_vga <= ~VS_ON;
      bus.HBLANK <= 1'b1; bus.VBLANK <= 1'b1;
      bus.RED <= '0; bus.GREEN <= '0; bus.BLUE <= '0;
    end else begin
      run <= 1'b1;
      div <= (div == DIV_MAX) ? '0 : div + 1'b1;
      if (tick) begin
        if (hi == H_TOTAL - 1) begin
          h <= '0;
          v <= (vi == V_TOTAL - 1) ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
        bus.CURX        <= h_act ? h : '0;
        bus.CURY        <= v_act ? v : '0;
        bus.DATA_REQ    <= h_act && v_act;
        bus.LINE_START  <= (hi == 0) && v_act;
        bus.FRAME_START <= at_origin;
        fl_pipe[0] <= nxt_fl;
        for (int i = 1; i < FETCH_LAT; i++) fl_pipe[i] <= fl_pipe[i-1];
        // Display stage: COLOR belongs to the fetch point FETCH_LAT ticks back.
        bus.hs_vga <= out_fl.hs ? HS_ON : ~HS_ON;
        bus.vs_vga <= out_fl.vs ? VS_ON : ~VS_ON;
        bus.HBLANK <= ~out_fl.hvis;
        bus.VBLANK <= ~out_fl.vvis;
        if (out_fl.hvis && out_fl.vvis) begin
          bus.RED   <= bus.COLOR[C_W-1 -: R_BITS];
          bus.GREEN <= bus.COLOR[B_BITS +: G_BITS];
          bus.BLUE  <= bus.COLOR[0 +: B_BITS];
        end else begin
          bus.RED <= '0; bus.GREEN <= '0; bus.BLUE <= '0;
        end
      end
    end
  end

  // Frame count survives ENABLE drops; only the async reset clears it.
  always_ff @(posedge clk_50MHz or negedge RESET_N) begin
    if (!RESET_N)
      bus.FRAME_CNT <= '0;
    else if (bus.ENABLE && tick && at_origin)
      bus.FRAME_CNT <= bus.FRAME_CNT + 1'b1;
  end
endmodule
